// File: rtl/multi_port_write_back_pkg.sv
// rtl/multi_port_write_back_pkg.sv - shared register indices, widths and types for the write-back stage
package multi_port_write_back_pkg;

  localparam int REG_N_DEF  = 18;
  localparam int DATA_W_DEF = 64;

  // Architectural register map: 16 GPRs in x86-64 encoding order, then RIP and EFL
  localparam int RAX = 0;
  localparam int RCX = 1;
  localparam int RDX = 2;
  localparam int RBX = 3;
  localparam int RSP = 4;
  localparam int RBP = 5;
  localparam int RIP = 16;
  localparam int EFL = 17;

  typedef logic [DATA_W_DEF-1:0]         reg_t;
  typedef logic [$clog2(REG_N_DEF)-1:0]  addr_t;

  typedef enum logic {
    FL_IDLE   = 1'b0,
    FL_ACTIVE = 1'b1
  } flush_state_e;

endpackage

// File: rtl/multi_port_write_back_if.sv
// rtl/multi_port_write_back_if.sv - write-back port bundle between execute (master) and write-back (slave)
interface multi_port_write_back_if #(
  parameter int WB_PORTS = 2,
  parameter int REG_N    = 18,
  parameter int DATA_W   = 64
);
  localparam int IDX_W = $clog2(REG_N);

  logic [WB_PORTS-1:0] wr_valid;
  logic [IDX_W-1:0]    wr_idx  [WB_PORTS];
  logic [DATA_W-1:0]   wr_data [WB_PORTS];
  logic                eflags_we;
  logic [DATA_W-1:0]   eflags;
  logic                br_taken;
  logic [DATA_W-1:0]   br_target;
  logic                stall_pc;
  logic [DATA_W-1:0]   gpr [REG_N];
  logic [DATA_W-1:0]   pc_to_fet;
  logic                flush;
  logic                wb_conflict;

  modport master (
    output wr_valid, wr_idx, wr_data, eflags_we, eflags, br_taken, br_target, stall_pc,
    input  gpr, pc_to_fet, flush, wb_conflict
  );

  modport slave (
    input  wr_valid, wr_idx, wr_data, eflags_we, eflags, br_taken, br_target, stall_pc,
    output gpr, pc_to_fet, flush, wb_conflict
  );

endinterface

// File: rtl/wb_flush_timer.sv
// rtl/wb_flush_timer.sv - reloadable flush window counter; a branch restarts the full window
module wb_flush_timer
  import multi_port_write_back_pkg::*;
#(
  parameter int LOAD_LATENCY = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic br_taken,
  output logic flush
);
  localparam int CW = $clog2(LOAD_LATENCY + 1);

  flush_state_e    state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reload rather than accumulate: the newest branch defines the squash horizon
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (br_taken) begin
      state_d = FL_ACTIVE;
      cnt_d   = CW'(LOAD_LATENCY);
    end else if (state_q == FL_ACTIVE) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == CW'(1)) ? FL_IDLE : FL_ACTIVE;
    end
  end

  assign flush = (state_q == FL_ACTIVE);

endmodule

// File: rtl/multi_port_write_back.sv
// rtl/multi_port_write_back.sv - multi-port register commit, RIP/PC queue and flush window; WB_CONFLICT_DETECT_EN enables the sticky collision flag
module multi_port_write_back
  import multi_port_write_back_pkg::*;
#(
  parameter int              WB_PORTS     = 2,
  parameter int              REG_N        = REG_N_DEF,
  parameter int              DATA_W       = DATA_W_DEF,
  parameter int              LOAD_LATENCY = 1,
  parameter longint unsigned INIT_RIP     = 0,
  parameter longint unsigned INIT_RSP     = 1024
) (
  input  logic                   clk,
  input  logic                   rstn,
  multi_port_write_back_if.slave wb
);
  localparam int IDX_W = $clog2(REG_N);
  localparam logic [DATA_W-1:0] RST_RIP = DATA_W'(INIT_RIP) - DATA_W'(LOAD_LATENCY);

  logic [DATA_W-1:0] gpr_q [REG_N];
  logic [DATA_W-1:0] gpr_d [REG_N];
  logic [DATA_W-1:0] pcq   [LOAD_LATENCY];
  logic [DATA_W-1:0] next_rip;
  logic [DATA_W-1:0] pc_last;
  logic              flush_q;

  assign pc_last = pcq[LOAD_LATENCY-1];

  always_comb begin
    next_rip = gpr_q[RIP] + DATA_W'(1);
    if (wb.br_taken)
      next_rip = wb.br_target;
    else if (wb.stall_pc)
      next_rip = pc_last;
  end

  // Later ports overwrite earlier ones, so the youngest write wins; indices >= REG_N match nothing
  always_comb begin
    for (int r = 0; r < REG_N; r++) begin
      gpr_d[r] = gpr_q[r];
      if (r == EFL && wb.eflags_we)
        gpr_d[r] = wb.eflags;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb.wr_valid[p] && wb.wr_idx[p] == IDX_W'(r))
          gpr_d[r] = wb.wr_data[p];
      end
    end
    gpr_d[RIP] = next_rip;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < REG_N; r++) begin
        if (r == RSP || r == RBP)
          gpr_q[r] <= DATA_W'(INIT_RSP);
        else if (r == RIP)
          gpr_q[r] <= RST_RIP;
        else
          gpr_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_N; r++)
        gpr_q[r] <= gpr_d[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < LOAD_LATENCY; i++)
        pcq[i] <= '0;
    end else if (!wb.stall_pc) begin
      pcq[0] <= gpr_q[RIP];
      for (int i = 1; i < LOAD_LATENCY; i++)
        pcq[i] <= pcq[i-1];
    end
  end

  wb_flush_timer #(
    .LOAD_LATENCY (LOAD_LATENCY)
  ) u_flush_timer (
    .clk      (clk),
    .rstn     (rstn),
    .br_taken (wb.br_taken),
    .flush    (flush_q)
  );

`ifdef WB_CONFLICT_DETECT_EN
  logic collide;
  logic conflict_q;

  always_comb begin
    collide = 1'b0;
    for (int p = 0; p < WB_PORTS; p++) begin
      for (int q = p + 1; q < WB_PORTS; q++) begin
        if (wb.wr_valid[p] && wb.wr_valid[q] && wb.wr_idx[p] == wb.wr_idx[q])
          collide = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      conflict_q <= 1'b0;
    else if (collide)
      conflict_q <= 1'b1;
  end

  assign wb.wb_conflict = conflict_q;
`else
  assign wb.wb_conflict = 1'b0;
`endif

  assign wb.gpr       = gpr_q;
  assign wb.pc_to_fet = pc_last;
  assign wb.flush     = flush_q;

endmodule

// File: tb/tb_multi_port_write_back.sv
// tb/tb_multi_port_write_back.sv - directed bench for multi_port_write_back (LOAD_LATENCY 2 and 3 instances)
module tb_multi_port_write_back;
  import multi_port_write_back_pkg::*;

  localparam logic [63:0] CONF_EXP =
`ifdef WB_CONFLICT_DETECT_EN
    64'd1;
`else
    64'd0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_port_write_back_if #(.WB_PORTS(2), .REG_N(18), .DATA_W(64)) bus_a ();
  multi_port_write_back_if #(.WB_PORTS(2), .REG_N(18), .DATA_W(64)) bus_b ();

  multi_port_write_back #(
    .WB_PORTS(2), .REG_N(18), .DATA_W(64), .LOAD_LATENCY(2), .INIT_RIP(64'h100), .INIT_RSP(1024)
  ) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .wb   (bus_a)
  );

  multi_port_write_back #(
    .WB_PORTS(2), .REG_N(18), .DATA_W(64), .LOAD_LATENCY(3), .INIT_RIP(0), .INIT_RSP(1024)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .wb   (bus_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_b();
    bus_b.wr_valid  = '0;
    bus_b.wr_idx[0] = '0;
    bus_b.wr_idx[1] = '0;
    bus_b.wr_data[0] = '0;
    bus_b.wr_data[1] = '0;
    bus_b.eflags_we = 1'b0;
    bus_b.eflags    = '0;
    bus_b.br_taken  = 1'b0;
    bus_b.br_target = '0;
    bus_b.stall_pc  = 1'b0;
  endtask

  task automatic write_b(input int p, input int idx, input logic [63:0] data);
    bus_b.wr_valid[p] = 1'b1;
    bus_b.wr_idx[p]   = 5'(idx);
    bus_b.wr_data[p]  = data;
  endtask

  initial begin
    bus_a.wr_valid   = '0;
    bus_a.wr_idx[0]  = '0;
    bus_a.wr_idx[1]  = '0;
    bus_a.wr_data[0] = '0;
    bus_a.wr_data[1] = '0;
    bus_a.eflags_we  = 1'b0;
    bus_a.eflags     = '0;
    bus_a.br_taken   = 1'b0;
    bus_a.br_target  = '0;
    bus_a.stall_pc   = 1'b0;
    idle_b();

    tick();
    tick();
    check_eq("a_rst_rip",   bus_a.gpr[RIP], 64'hFE);
    check_eq("a_rst_rsp",   bus_a.gpr[RSP], 64'd1024);
    check_eq("a_rst_rbp",   bus_a.gpr[RBP], 64'd1024);
    check_eq("a_rst_rax",   bus_a.gpr[RAX], 64'd0);
    check_eq("a_rst_flush", 64'(bus_a.flush), 64'd0);
    check_eq("a_rst_pc",    bus_a.pc_to_fet, 64'd0);
    check_eq("b_rst_rip",   bus_b.gpr[RIP], 64'hFFFF_FFFF_FFFF_FFFD);
    check_eq("b_rst_conf",  64'(bus_b.wb_conflict), 64'd0);

    rstn = 1'b1;
    tick();
    tick();
    tick();
    check_eq("a_run_rip", bus_a.gpr[RIP], 64'h101);
    check_eq("a_run_pc",  bus_a.pc_to_fet, 64'hFF);
    check_eq("b_wrap_rip", bus_b.gpr[RIP], 64'h0);
    check_eq("b_run_pc",  bus_b.pc_to_fet, 64'hFFFF_FFFF_FFFF_FFFD);

    write_b(0, RAX, 64'd5);
    write_b(1, RAX, 64'd9);
    tick();
    idle_b();
    check_eq("same_idx_rax", bus_b.gpr[RAX], 64'd9);
    check_eq("conflict",     64'(bus_b.wb_conflict), CONF_EXP);
    check_eq("rip_after_wr", bus_b.gpr[RIP], 64'd1);

    bus_b.eflags_we = 1'b1;
    bus_b.eflags    = 64'h55;
    write_b(0, EFL, 64'h77);
    write_b(1, RBX, 64'h33);
    tick();
    idle_b();
    check_eq("efl_port_wins", bus_b.gpr[EFL], 64'h77);
    check_eq("rbx_write",     bus_b.gpr[RBX], 64'h33);

    bus_b.eflags_we = 1'b1;
    bus_b.eflags    = 64'h44;
    tick();
    idle_b();
    check_eq("efl_only", bus_b.gpr[EFL], 64'h44);
    check_eq("rip_3",    bus_b.gpr[RIP], 64'd3);

    write_b(0, RIP, 64'h500);
    write_b(1, 20, 64'hDEAD);
    tick();
    idle_b();
    check_eq("rip_wr_dropped", bus_b.gpr[RIP], 64'd4);
    check_eq("oor_rsp_kept",   bus_b.gpr[RSP], 64'd1024);
    check_eq("oor_rbp_kept",   bus_b.gpr[RBP], 64'd1024);

    bus_b.br_taken  = 1'b1;
    bus_b.br_target = 64'h200;
    tick();
    idle_b();
    check_eq("br_rip",    bus_b.gpr[RIP], 64'h200);
    check_eq("br_flush1", 64'(bus_b.flush), 64'd1);
    tick();
    check_eq("br_flush2", 64'(bus_b.flush), 64'd1);
    tick();
    check_eq("br_flush3", 64'(bus_b.flush), 64'd1);
    tick();
    check_eq("br_flush_end", 64'(bus_b.flush), 64'd0);
    check_eq("br_rip_run",   bus_b.gpr[RIP], 64'h203);

    bus_b.br_taken  = 1'b1;
    bus_b.br_target = 64'h300;
    tick();
    idle_b();
    check_eq("br2_rip1", bus_b.gpr[RIP], 64'h300);
    tick();
    check_eq("br2_flush_m1", 64'(bus_b.flush), 64'd1);
    bus_b.br_taken  = 1'b1;
    bus_b.br_target = 64'h400;
    tick();
    idle_b();
    check_eq("br2_rip2",     bus_b.gpr[RIP], 64'h400);
    check_eq("br2_flush_m2", 64'(bus_b.flush), 64'd1);
    tick();
    check_eq("br2_flush_m3", 64'(bus_b.flush), 64'd1);
    tick();
    check_eq("br2_flush_m4", 64'(bus_b.flush), 64'd1);
    tick();
    check_eq("br2_flush_end", 64'(bus_b.flush), 64'd0);
    check_eq("br2_rip_run",   bus_b.gpr[RIP], 64'h403);
    check_eq("br2_pc",        bus_b.pc_to_fet, 64'h400);
    check_eq("conflict_sticky", 64'(bus_b.wb_conflict), CONF_EXP);

    bus_b.stall_pc = 1'b1;
    tick();
    check_eq("stall1_rip", bus_b.gpr[RIP], 64'h400);
    check_eq("stall1_pc",  bus_b.pc_to_fet, 64'h400);
    tick();
    check_eq("stall2_rip", bus_b.gpr[RIP], 64'h400);
    check_eq("stall2_pc",  bus_b.pc_to_fet, 64'h400);
    bus_b.stall_pc = 1'b0;
    tick();
    check_eq("resume1_pc",  bus_b.pc_to_fet, 64'h401);
    check_eq("resume1_rip", bus_b.gpr[RIP], 64'h401);
    tick();
    check_eq("resume2_pc", bus_b.pc_to_fet, 64'h402);
    tick();
    check_eq("resume3_pc",  bus_b.pc_to_fet, 64'h400);
    check_eq("resume3_rip", bus_b.gpr[RIP], 64'h403);

    bus_b.stall_pc  = 1'b1;
    bus_b.br_taken  = 1'b1;
    bus_b.br_target = 64'h600;
    tick();
    idle_b();
    check_eq("stall_br_rip",   bus_b.gpr[RIP], 64'h600);
    check_eq("stall_br_pc",    bus_b.pc_to_fet, 64'h400);
    check_eq("stall_br_flush", 64'(bus_b.flush), 64'd1);

    rstn = 1'b0;
    tick();
    check_eq("midrst_flush", 64'(bus_b.flush), 64'd0);
    check_eq("midrst_rip",   bus_b.gpr[RIP], 64'hFFFF_FFFF_FFFF_FFFD);
    check_eq("midrst_rax",   bus_b.gpr[RAX], 64'd0);
    check_eq("midrst_efl",   bus_b.gpr[EFL], 64'd0);
    check_eq("midrst_conf",  64'(bus_b.wb_conflict), 64'd0);
    rstn = 1'b1;
    tick();
    check_eq("post_rst_flush", 64'(bus_b.flush), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
